input_daemon: RTL

- Ingress-side packet demultiplexer for one input port of the 4x4 switch.
- Accepts a 32-bit word stream carrying packets, parses each header for destination and length, and writes every packet word as a 33-bit {valid, data} word into one of four per-destination non-blocking output buffers.
- It is the writer for those buffers; the output-side arbiter on each port is the reader.

---
 rtl/switch_pkg.sv | 32 +++
 rtl/input_daemon_header_decode.sv | 22 ++
 rtl/input_daemon.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the 4x4 switch: widths, header field positions,
// ingress FSM states and the {valid, data} buffer word.
package switch_pkg;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 16;
    localparam int NUM_DST = 4;
    localparam int DST_W   = 2;
    localparam int BUF_W   = DATA_W + 1;

    // Header field positions
    localparam int LEN_MSB = 23;
    localparam int LEN_LSB = 8;
    localparam int MID_MSB = 7;
    localparam int MID_LSB = 2;
    localparam int DST_MSB = 1;
    localparam int DST_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } state_t;

    // Word written into a destination buffer; valid flag sits at the MSB
    typedef logic [BUF_W-1:0] buf_word_t;

    function automatic buf_word_t make_buf_word(input logic [DATA_W-1:0] data);
        return {1'b1, data};
    endfunction

endpackage

// File: rtl/input_daemon_header_decode.sv
// header_decode: pulls destination, destination validity and the clamped
// packet length out of a header word. Purely combinational.
module header_decode
    import switch_pkg::*;
(
    input  logic [DATA_W-1:0] hdr,
    output logic [DST_W-1:0]  dest,
    output logic              dest_ok,
    output logic [LEN_W-1:0]  len
);

    // Field extraction; a zero length is treated as a header-only packet
    always_comb begin
        dest    = hdr[DST_MSB:DST_LSB];
        dest_ok = (hdr[MID_MSB:MID_LSB] == '0);
        len     = hdr[LEN_MSB:LEN_LSB];
        if (len == '0) begin
            len = LEN_W'(1);
        end
    end

endmodule

// File: rtl/input_daemon.sv
// input_daemon: ingress demultiplexer. Parses packet headers and writes each
// packet word, tagged valid, into one of four destination buffers. Words with
// an invalid destination are consumed and discarded.
// Optional macro INPUT_DAEMON_STATS_EN adds pkt_count / drop_count outputs.
module input_daemon
    import switch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  INPUT_PORT,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_DST-1:0] buf_full,
    output logic [BUF_W-1:0]   NOBLOCKOBUF_TO_1,
    output logic [BUF_W-1:0]   NOBLOCKOBUF_TO_2,
    output logic [BUF_W-1:0]   NOBLOCKOBUF_TO_3,
    output logic [BUF_W-1:0]   NOBLOCKOBUF_TO_4
`ifdef INPUT_DAEMON_STATS_EN
    ,
    output logic [15:0]        pkt_count,
    output logic [15:0]        drop_count
`endif
);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [DST_W-1:0] dst_reg, dst_next;
    logic             ready;
    logic             xfer;
    logic             wr_en;
    logic [DST_W-1:0] wr_sel;

    logic [DST_W-1:0] dec_dest;
    logic             dec_dest_ok;
    logic [LEN_W-1:0] dec_len;

    buf_word_t        out_reg [NUM_DST];

    header_decode u_header_decode (
        .hdr     (INPUT_PORT),
        .dest    (dec_dest),
        .dest_ok (dec_dest_ok),
        .len     (dec_len)
    );

    // Ready is forced low while reset is held so nothing is accepted
    assign in_ready = ready & rst_n;
    assign xfer     = in_valid & ready;

    // FSM state, word counter and latched destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dst_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dst_reg   <= dst_next;
        end
    end

    // Ready generation, next-state logic and buffer write selection
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dst_next   = dst_reg;
        ready      = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = dst_reg;

        case (state_reg)
            IDLE: begin
                // Invalid-destination headers are always swallowed
                ready = dec_dest_ok ? ~buf_full[dec_dest] : 1'b1;
                if (xfer) begin
                    cnt_next = dec_len - LEN_W'(1);
                    if (dec_dest_ok) begin
                        wr_en    = 1'b1;
                        wr_sel   = dec_dest;
                        dst_next = dec_dest;
                        if (dec_len > LEN_W'(1)) begin
                            state_next = FORWARD;
                        end
                    end else if (dec_len > LEN_W'(1)) begin
                        state_next = DROP;
                    end
                end
            end

            FORWARD: begin
                ready = ~buf_full[dst_reg];
                if (xfer) begin
                    wr_en  = 1'b1;
                    wr_sel = dst_reg;
                    if (cnt_reg <= LEN_W'(1)) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - LEN_W'(1);
                    end
                end
            end

            DROP: begin
                ready = 1'b1;
                if (xfer) begin
                    if (cnt_reg <= LEN_W'(1)) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - LEN_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // One registered output per destination; only the written one is valid
    generate
        for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg[gi] <= '0;
                end else if (wr_en && (wr_sel == DST_W'(gi))) begin
                    out_reg[gi] <= make_buf_word(INPUT_PORT);
                end else begin
                    out_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    assign NOBLOCKOBUF_TO_1 = out_reg[0];
    assign NOBLOCKOBUF_TO_2 = out_reg[1];
    assign NOBLOCKOBUF_TO_3 = out_reg[2];
    assign NOBLOCKOBUF_TO_4 = out_reg[3];

`ifdef INPUT_DAEMON_STATS_EN
    logic hdr_xfer;
    logic [15:0] pkt_count_reg;
    logic [15:0] drop_count_reg;

    assign hdr_xfer = (state_reg == IDLE) & xfer;

    // Saturating header counters, split by destination validity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
        end else if (hdr_xfer) begin
            if (dec_dest_ok) begin
                if (pkt_count_reg != 16'hFFFF) begin
                    pkt_count_reg <= pkt_count_reg + 16'd1;
                end
            end else begin
                if (drop_count_reg != 16'hFFFF) begin
                    drop_count_reg <= drop_count_reg + 16'd1;
                end
            end
        end
    end

    assign pkt_count  = pkt_count_reg;
    assign drop_count = drop_count_reg;
`endif

endmodule
